// File: rtl/pwm_update_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pwm_ctrl_pkg
//  Brief    : Shared types, register map and helpers for pwm_update_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_t;

    // How the active compare registers are updated on the next edge
    typedef enum logic [1:0] {
        CMP_HOLD  = 2'd0,
        CMP_CLEAR = 2'd1,
        CMP_STEP  = 2'd2,
        CMP_TRACK = 2'd3
    } cmp_op_t;

    // Register map (compare[n] lives at address n)
    localparam logic [3:0] ADDR_MAX    = 4'd8;
    localparam logic [3:0] ADDR_STEP   = 4'd9;
    localparam logic [3:0] ADDR_DT     = 4'd10;
    localparam logic [3:0] ADDR_COMMIT = 4'd15;

    // True for any address that selects a register or the commit strobe
    function automatic logic addr_is_mapped(input logic [3:0] addr, input int phase_count);
        return (int'(addr) < phase_count) || (addr == ADDR_MAX) || (addr == ADDR_STEP) ||
               (addr == ADDR_DT) || (addr == ADDR_COMMIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_update_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pwm_update_ctrl_if
//  Brief    : Configuration write port (valid/ready plus error pulse).
//  Revision : 1.0 - initial release
// ============================================================================
interface pwm_update_ctrl_if
    import pwm_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH = 16
);
    logic                 CfgValid;
    logic                 CfgReady;
    logic [3:0]           CfgAddr;
    logic [BIT_WIDTH-1:0] CfgData;
    logic                 CfgErr;

    modport master (output CfgValid, output CfgAddr, output CfgData,
                    input  CfgReady, input  CfgErr);
    modport slave  (input  CfgValid, input  CfgAddr, input  CfgData,
                    output CfgReady, output CfgErr);
endinterface
`default_nettype wire

// File: rtl/pwm_update_ctrl_ramp_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pwm_ramp_step
//  Brief    : One saturating step of a compare value toward its goal, moving
//             at most RampStep per call, never overshooting or wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_step
#(
    parameter int BIT_WIDTH = 16,
    parameter int RampStep  = 4
)(
    input  logic [BIT_WIDTH-1:0] cur,
    input  logic [BIT_WIDTH-1:0] tgt,
    output logic [BIT_WIDTH-1:0] nxt,
    output logic                 at_target
);
    // One extra bit so cur+step cannot wrap and cur-step shows a borrow
    localparam logic [BIT_WIDTH:0] STEP_X = (BIT_WIDTH+1)'(RampStep);

    logic [BIT_WIDTH:0] cur_x;
    logic [BIT_WIDTH:0] tgt_x;
    logic [BIT_WIDTH:0] up_x;
    logic [BIT_WIDTH:0] down_x;

    assign cur_x  = {1'b0, cur};
    assign tgt_x  = {1'b0, tgt};
    assign up_x   = cur_x + STEP_X;
    assign down_x = cur_x - STEP_X;

    // Land on the goal whenever a full step would reach or pass it
    always_comb begin
        nxt = tgt;
        if (cur_x < tgt_x) begin
            if (up_x < tgt_x) begin
                nxt = up_x[BIT_WIDTH-1:0];
            end
        end else if (cur_x > tgt_x) begin
            if (!down_x[BIT_WIDTH] && (down_x > tgt_x)) begin
                nxt = down_x[BIT_WIDTH-1:0];
            end
        end
    end

    assign at_target = (nxt == tgt);

endmodule
`default_nettype wire

// File: rtl/pwm_update_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pwm_update_ctrl
//  Brief    : Shadow-register configuration front end for PWMGenTop. Writes
//             land in shadows, a commit applies them atomically (at once in
//             IDLE, otherwise at the carrier zero point), and a small FSM
//             sequences reset release, soft ramp-up and ramp-down.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_update_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int PhaseCount = 3,
    parameter int BIT_WIDTH  = 16,
    parameter int RampStep   = 4
)(
    input  logic                                 MClk,
    input  logic                                 RstN,
    pwm_update_ctrl_if.slave                     cfg,
    input  logic                                 Enable,
    input  logic                                 CarrierZero,
    output logic [PhaseCount-1:0][BIT_WIDTH-1:0] Compare,
    output logic [BIT_WIDTH-1:0]                 PWMMaxCount,
    output logic [BIT_WIDTH-1:0]                 TriangleStepSize,
    output logic [BIT_WIDTH-1:0]                 DeadTimeCount,
    output logic                                 PWMRstN,
    output logic                                 Busy
);

    state_t  state;
    state_t  state_next;
    cmp_op_t cmp_op;
    logic    pwm_rstn_next;

    logic    pending;
    logic    cfg_err_q;
    logic    accept;
    logic    apply;
    logic    cfg_ok;
    logic    all_done;

    logic [PhaseCount-1:0][BIT_WIDTH-1:0] sh_cmp;
    logic [BIT_WIDTH-1:0]                 sh_max;
    logic [BIT_WIDTH-1:0]                 sh_step;
    logic [BIT_WIDTH-1:0]                 sh_dt;

    logic [PhaseCount-1:0][BIT_WIDTH-1:0] target;
    logic [PhaseCount-1:0][BIT_WIDTH-1:0] tgt_next;
    logic [PhaseCount-1:0][BIT_WIDTH-1:0] ramp_goal;
    logic [PhaseCount-1:0][BIT_WIDTH-1:0] ramp_val;
    logic [PhaseCount-1:0][BIT_WIDTH-1:0] cmp_next;
    logic [PhaseCount-1:0]                ramp_done;

    // Writes are refused only while a commit waits for a carrier zero
    assign cfg.CfgReady = !(pending && (state != IDLE));
    assign cfg.CfgErr   = cfg_err_q;
    assign accept       = cfg.CfgValid && cfg.CfgReady;
    assign apply        = pending && ((state == IDLE) || CarrierZero);
    assign cfg_ok       = (PWMMaxCount != '0) && (TriangleStepSize != '0);
    assign all_done     = &ramp_done;
    assign Busy         = (state != IDLE);

    // Per-phase clamp, target selection and ramp stepper
    for (genvar n = 0; n < PhaseCount; n++) begin : g_phase
        logic [BIT_WIDTH-1:0] clamped;
        assign clamped      = (sh_cmp[n] > sh_max) ? sh_max : sh_cmp[n];
        assign tgt_next[n]  = apply ? clamped : target[n];
        // Ramp-down ignores targets entirely and heads for zero
        assign ramp_goal[n] = (state == STOP) ? '0 : tgt_next[n];

        pwm_ramp_step #(
            .BIT_WIDTH (BIT_WIDTH),
            .RampStep  (RampStep)
        ) u_step (
            .cur       (Compare[n]),
            .tgt       (ramp_goal[n]),
            .nxt       (ramp_val[n]),
            .at_target (ramp_done[n])
        );
    end

    // Shadow registers capture every accepted write to a mapped register
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            sh_cmp  <= '0;
            sh_max  <= '0;
            sh_step <= '0;
            sh_dt   <= '0;
        end else if (accept) begin
            for (int n = 0; n < PhaseCount; n++) begin
                if (cfg.CfgAddr == 4'(n)) begin
                    sh_cmp[n] <= cfg.CfgData;
                end
            end
            case (cfg.CfgAddr)
                ADDR_MAX:  sh_max  <= cfg.CfgData;
                ADDR_STEP: sh_step <= cfg.CfgData;
                ADDR_DT:   sh_dt   <= cfg.CfgData;
                default:   ;
            endcase
        end
    end

    // Commit flag and one-cycle error pulse for unmapped writes
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            pending   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= accept && !addr_is_mapped(cfg.CfgAddr, PhaseCount);
            if (accept && (cfg.CfgAddr == ADDR_COMMIT)) begin
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    // Atomic transfer of all shadow fields into the active set
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            PWMMaxCount      <= '0;
            TriangleStepSize <= '0;
            DeadTimeCount    <= '0;
            target           <= '0;
        end else if (apply) begin
            PWMMaxCount      <= sh_max;
            TriangleStepSize <= sh_step;
            DeadTimeCount    <= sh_dt;
            target           <= tgt_next;
        end
    end

    // Sequencer state register
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            state   <= IDLE;
            PWMRstN <= 1'b0;
        end else begin
            state   <= state_next;
            PWMRstN <= pwm_rstn_next;
        end
    end

    // Sequencer next state, PWMGenTop reset and compare update selection
    always_comb begin
        state_next    = state;
        pwm_rstn_next = PWMRstN;
        cmp_op        = CMP_HOLD;
        case (state)
            IDLE: begin
                cmp_op = CMP_CLEAR;
                if (Enable && cfg_ok) begin
                    state_next    = RAMP;
                    pwm_rstn_next = 1'b1;
                end
            end
            RAMP: begin
                if (CarrierZero) begin
                    cmp_op = CMP_STEP;
                end
                if (!Enable) begin
                    state_next = STOP;
                end else if (CarrierZero && all_done) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                cmp_op = CMP_TRACK;
                if (!Enable) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (CarrierZero) begin
                    cmp_op = CMP_STEP;
                    if (all_done) begin
                        state_next    = IDLE;
                        pwm_rstn_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                pwm_rstn_next = 1'b0;
            end
        endcase
    end

    // Next compare values according to the selected update
    always_comb begin
        cmp_next = Compare;
        case (cmp_op)
            CMP_CLEAR: cmp_next = '0;
            CMP_STEP:  cmp_next = ramp_val;
            CMP_TRACK: cmp_next = tgt_next;
            default:   cmp_next = Compare;
        endcase
    end

    // Active compare registers driven to PWMGenTop
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            Compare <= '0;
        end else begin
            Compare <= cmp_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_update_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_update_ctrl
//  Brief    : Directed bench for pwm_update_ctrl. Stimulus queues expected
//             output values tagged with the cycle they must appear in; a
//             separate monitor compares them mid-cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_update_ctrl;
    import pwm_ctrl_pkg::*;

    localparam int PHASES = 3;
    localparam int W      = 16;
    localparam int STEP   = 4;
    localparam int CZ_GAP = 8;

    localparam int SEL_CMP   = 0;
    localparam int SEL_MAX   = 1;
    localparam int SEL_TSTEP = 2;
    localparam int SEL_DT    = 3;
    localparam int SEL_PRST  = 4;
    localparam int SEL_BUSY  = 5;
    localparam int SEL_READY = 6;
    localparam int SEL_ERR   = 7;

    typedef struct {
        int          cyc;
        int          sel;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    logic                         MClk;
    logic                         RstN;
    logic                         Enable;
    logic                         CarrierZero;
    logic [PHASES-1:0][W-1:0]     Compare;
    logic [W-1:0]                 PWMMaxCount;
    logic [W-1:0]                 TriangleStepSize;
    logic [W-1:0]                 DeadTimeCount;
    logic                         PWMRstN;
    logic                         Busy;

    pwm_update_ctrl_if #(.BIT_WIDTH(W)) cfg_bus ();

    pwm_update_ctrl #(
        .PhaseCount (PHASES),
        .BIT_WIDTH  (W),
        .RampStep   (STEP)
    ) dut (
        .MClk             (MClk),
        .RstN             (RstN),
        .cfg              (cfg_bus),
        .Enable           (Enable),
        .CarrierZero      (CarrierZero),
        .Compare          (Compare),
        .PWMMaxCount      (PWMMaxCount),
        .TriangleStepSize (TriangleStepSize),
        .DeadTimeCount    (DeadTimeCount),
        .PWMRstN          (PWMRstN),
        .Busy             (Busy)
    );

    exp_t sb[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    initial MClk = 1'b0;
    always #5 MClk = ~MClk;

    always @(posedge MClk) cyc <= cyc + 1;

    function automatic logic [31:0] probe(input int sel, input int idx);
        case (sel)
            SEL_CMP:   return 32'(Compare[idx]);
            SEL_MAX:   return 32'(PWMMaxCount);
            SEL_TSTEP: return 32'(TriangleStepSize);
            SEL_DT:    return 32'(DeadTimeCount);
            SEL_PRST:  return 32'(PWMRstN);
            SEL_BUSY:  return 32'(Busy);
            SEL_READY: return 32'(cfg_bus.CfgReady);
            default:   return 32'(cfg_bus.CfgErr);
        endcase
    endfunction

    function automatic string sig_name(input int sel);
        case (sel)
            SEL_CMP:   return "Compare";
            SEL_MAX:   return "PWMMaxCount";
            SEL_TSTEP: return "TriangleStepSize";
            SEL_DT:    return "DeadTimeCount";
            SEL_PRST:  return "PWMRstN";
            SEL_BUSY:  return "Busy";
            SEL_READY: return "CfgReady";
            default:   return "CfgErr";
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle
    always @(negedge MClk) begin
        int          i;
        logic [31:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                act = probe(sb[i].sel, sb[i].idx);
                n_check++;
                if (act !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s[%0d] cycle %0d: got %0d, expected %0d",
                             sig_name(sb[i].sel), sb[i].idx, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_check++;
                n_fail++;
                $display("FAIL stale_%s[%0d]: due cycle %0d, never checked",
                         sig_name(sb[i].sel), sb[i].idx, sb[i].cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic push_exp(input int off, input int sel, input int idx, input int v);
        exp_t e;
        e.cyc = cyc + off;
        e.sel = sel;
        e.idx = idx;
        e.exp = 32'(v);
        sb.push_back(e);
    endtask

    task automatic push_cmps(input int off, input int a, input int b, input int c);
        push_exp(off, SEL_CMP, 0, a);
        push_exp(off, SEL_CMP, 1, b);
        push_exp(off, SEL_CMP, 2, c);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic tick();
        @(posedge MClk);
        #1;
    endtask

    task automatic pulse();
        CarrierZero = 1'b1;
        tick();
        CarrierZero = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] a, input int d);
        int n;
        n = 0;
        cfg_bus.CfgValid = 1'b1;
        cfg_bus.CfgAddr  = a;
        cfg_bus.CfgData  = W'(d);
        while (!cfg_bus.CfgReady && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_check++;
            n_fail++;
            $display("FAIL cfg_write_timeout addr %0d: CfgReady=0, expected 1 within 50 cycles", a);
        end
        tick();
        cfg_bus.CfgValid = 1'b0;
    endtask

    // Ramp from zero to targets {300,150,500}, one check set per pulse
    task automatic ramp_up();
        for (int k = 1; k <= 125; k++) begin
            repeat (CZ_GAP) tick();
            pulse();
            push_cmps(0, imin(STEP*k, 300), imin(STEP*k, 150), imin(STEP*k, 500));
        end
        push_exp(0, SEL_BUSY, 0, 1);
        push_exp(0, SEL_PRST, 0, 1);
    endtask

    initial begin
        int w;
        RstN             = 1'b0;
        Enable           = 1'b0;
        CarrierZero      = 1'b0;
        cfg_bus.CfgValid = 1'b0;
        cfg_bus.CfgAddr  = 4'd0;
        cfg_bus.CfgData  = '0;

        // Reset values
        tick();
        push_cmps(0, 0, 0, 0);
        push_exp(0, SEL_MAX, 0, 0);
        push_exp(0, SEL_PRST, 0, 0);
        push_exp(0, SEL_BUSY, 0, 0);
        push_exp(0, SEL_READY, 0, 1);
        push_exp(0, SEL_ERR, 0, 0);
        tick();
        RstN = 1'b1;
        repeat (2) tick();

        // Unmapped address: one-cycle error pulse
        cfg_write(4'd5, 16'h1234);
        push_exp(0, SEL_ERR, 0, 1);
        push_exp(1, SEL_ERR, 0, 0);
        push_exp(1, SEL_READY, 0, 1);
        repeat (2) tick();

        // Invalid config (max=0): commit applies in IDLE the next edge, Enable ignored
        cfg_write(ADDR_STEP, 2);
        cfg_write(ADDR_COMMIT, 0);
        push_exp(0, SEL_TSTEP, 0, 0);
        push_exp(1, SEL_TSTEP, 0, 2);
        Enable = 1'b1;
        push_exp(3, SEL_PRST, 0, 0);
        push_exp(3, SEL_BUSY, 0, 0);
        push_exp(3, SEL_MAX, 0, 0);
        repeat (4) tick();
        Enable = 1'b0;
        tick();

        // Bring-up: compare[2]=600 clamps to max 500
        cfg_write(4'd0, 300);
        cfg_write(4'd1, 150);
        cfg_write(4'd2, 600);
        cfg_write(ADDR_MAX, 500);
        cfg_write(ADDR_STEP, 2);
        cfg_write(ADDR_DT, 5);
        cfg_write(ADDR_COMMIT, 0);
        tick();
        push_exp(0, SEL_MAX, 0, 500);
        push_exp(0, SEL_DT, 0, 5);
        push_exp(0, SEL_TSTEP, 0, 2);
        push_exp(0, SEL_PRST, 0, 0);
        Enable = 1'b1;
        tick();
        push_exp(0, SEL_PRST, 0, 1);
        push_exp(0, SEL_BUSY, 0, 1);
        push_cmps(0, 0, 0, 0);
        ramp_up();

        // Atomic update in RUN: shadow writes alone change nothing
        repeat (3) tick();
        cfg_write(ADDR_MAX, 400);
        cfg_write(4'd0, 350);
        push_exp(0, SEL_MAX, 0, 500);
        push_cmps(0, 300, 150, 500);
        cfg_write(ADDR_COMMIT, 0);
        push_exp(0, SEL_READY, 0, 0);
        repeat (3) tick();
        push_exp(0, SEL_READY, 0, 0);
        push_exp(0, SEL_MAX, 0, 500);
        push_cmps(0, 300, 150, 500);
        pulse();
        push_exp(0, SEL_MAX, 0, 400);
        push_cmps(0, 350, 150, 400);
        push_exp(0, SEL_READY, 0, 1);

        // Commit accepted together with CarrierZero waits for the next pulse
        repeat (3) tick();
        cfg_write(4'd1, 100);
        cfg_bus.CfgValid = 1'b1;
        cfg_bus.CfgAddr  = ADDR_COMMIT;
        CarrierZero      = 1'b1;
        tick();
        cfg_bus.CfgValid = 1'b0;
        CarrierZero      = 1'b0;
        push_cmps(0, 350, 150, 400);
        push_exp(0, SEL_READY, 0, 0);
        repeat (CZ_GAP) tick();
        push_exp(0, SEL_CMP, 1, 150);
        pulse();
        push_cmps(0, 350, 100, 400);
        push_exp(0, SEL_READY, 0, 1);

        // Restore {300,150,500} for shutdown
        repeat (2) tick();
        cfg_write(4'd0, 300);
        cfg_write(4'd1, 150);
        cfg_write(ADDR_MAX, 500);
        cfg_write(ADDR_COMMIT, 0);
        repeat (2) tick();
        pulse();
        push_exp(0, SEL_MAX, 0, 500);
        push_cmps(0, 300, 150, 500);

        // Shutdown with Enable re-raised during STOP
        repeat (2) tick();
        Enable = 1'b0;
        tick();
        push_exp(0, SEL_BUSY, 0, 1);
        push_exp(0, SEL_PRST, 0, 1);
        repeat (2) tick();
        Enable = 1'b1;
        for (int k = 1; k <= 125; k++) begin
            repeat (CZ_GAP) tick();
            pulse();
            push_cmps(0, imax(300 - STEP*k, 0), imax(150 - STEP*k, 0), imax(500 - STEP*k, 0));
            push_exp(0, SEL_PRST, 0, (k == 125) ? 0 : 1);
            push_exp(0, SEL_BUSY, 0, (k == 125) ? 0 : 1);
        end
        // Enable still high is sampled again in IDLE
        tick();
        push_exp(0, SEL_PRST, 0, 1);
        push_exp(0, SEL_BUSY, 0, 1);

        // Reach RUN again, then reset asynchronously mid-cycle
        ramp_up();
        repeat (3) tick();
        #1;
        RstN = 1'b0;
        push_cmps(0, 0, 0, 0);
        push_exp(0, SEL_MAX, 0, 0);
        push_exp(0, SEL_TSTEP, 0, 0);
        push_exp(0, SEL_DT, 0, 0);
        push_exp(0, SEL_PRST, 0, 0);
        push_exp(0, SEL_BUSY, 0, 0);
        push_exp(0, SEL_READY, 0, 1);
        tick();
        RstN = 1'b1;

        w = 0;
        while (sb.size() > 0 && w < 20) begin
            tick();
            w++;
        end
        if (sb.size() > 0) begin
            n_check++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
